// File: rtl/ysyx_22041752_clint_pkg.sv
// Shared CLINT constants: window base, register offsets, FSM and decode encodings.
package ysyx_22041752_clint_pkg;

  localparam logic [31:0] CLINT_BASE     = 32'h0200_0000;
  localparam logic [15:0] CLINT_MSIP     = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP = 16'h4000;
  localparam logic [15:0] CLINT_MTIME    = 16'hBFF8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } clint_state_t;

  typedef enum logic [1:0] {
    SEL_NONE     = 2'd0,
    SEL_MSIP     = 2'd1,
    SEL_MTIMECMP = 2'd2,
    SEL_MTIME    = 2'd3
  } clint_sel_t;

  function automatic logic [63:0] merge_bytes(input logic [63:0] old_val,
                                               input logic [63:0] new_val,
                                               input logic [7:0]  strb);
    logic [63:0] res;
    res = old_val;
    for (int i = 0; i < 8; i++) begin
      if (strb[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ysyx_22041752_clint_tick.sv
// mtime prescaler: tick pulses once every TICK_DIV core clocks (every cycle when TICK_DIV is 1).
module ysyx_22041752_clint_tick #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(TICK_DIV - 1);

  logic [15:0] div_cnt;

  assign tick = (div_cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/ysyx_22041752_clint.sv
// Core-local interruptor: mtime/mtimecmp/msip behind a single-outstanding valid/ready bus.
// Response one cycle after accept and held until resp_ready; no request is taken while a response is pending.
module ysyx_22041752_clint
  import ysyx_22041752_clint_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = CLINT_BASE,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        int_t_o,
  output logic        int_s_o
);

  clint_state_t state, state_nxt;
  clint_sel_t   sel;
  logic         tick;
  logic         accept;
  logic         wr;
  logic [63:0]  mtime;
  logic [63:0]  mtimecmp;
  logic [63:0]  rd_mux;
  logic         msip;
  logic         unused;

  ysyx_22041752_clint_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  assign unused = ^req_addr[2:0];

  // Address decode: 8-byte aligned offsets inside the 64 KiB window.
  always_comb begin
    sel = SEL_NONE;
    if (req_addr[31:16] == BASE_ADDR[31:16]) begin
      case ({req_addr[15:3], 3'b000})
        CLINT_MSIP:     sel = SEL_MSIP;
        CLINT_MTIMECMP: sel = SEL_MTIMECMP;
        CLINT_MTIME:    sel = SEL_MTIME;
        default:        sel = SEL_NONE;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (sel)
      SEL_MSIP:     rd_mux = {63'd0, msip};
      SEL_MTIMECMP: rd_mux = mtimecmp;
      SEL_MTIME:    rd_mux = mtime;
      default:      rd_mux = '0;
    endcase
  end

  assign accept = req_valid && req_ready;
  assign wr     = accept && req_wen;

  // A bus write to mtime discards that cycle's increment for every byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      mtime <= '0;
    end else if (wr && (sel == SEL_MTIME)) begin
      mtime <= merge_bytes(mtime, req_wdata, req_wstrb);
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mtimecmp <= '1;
      msip     <= 1'b0;
    end else begin
      if (wr && (sel == SEL_MTIMECMP)) begin
        mtimecmp <= merge_bytes(mtimecmp, req_wdata, req_wstrb);
      end
      if (wr && (sel == SEL_MSIP) && req_wstrb[0]) begin
        msip <= req_wdata[0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      int_t_o <= 1'b0;
      int_s_o <= 1'b0;
    end else begin
      int_t_o <= (mtime >= mtimecmp);
      int_s_o <= msip;
    end
  end

  // Response payload is captured once at accept and held through RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (accept) begin
      resp_rdata <= req_wen ? 64'd0 : rd_mux;
      resp_err   <= (sel == SEL_NONE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req_valid) state_nxt = ST_RESP;
      ST_RESP: if (resp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      ST_IDLE: req_ready  = 1'b1;
      ST_RESP: resp_valid = 1'b1;
      default: req_ready  = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_ysyx_22041752_clint.sv
// Bench for the CLINT: two instances (TICK_DIV 4 and 1) against an arithmetic mtime model.
module tb_ysyx_22041752_clint;

  localparam logic [31:0] BASE = 32'h0200_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_wen    [2];
  logic [31:0] req_addr   [2];
  logic [63:0] req_wdata  [2];
  logic [7:0]  req_wstrb  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [63:0] resp_rdata [2];
  logic        resp_err   [2];
  logic        int_t_o    [2];
  logic        int_s_o    [2];

  int checks = 0;
  int errors = 0;
  int ecnt;
  bit mon_en = 1'b0;

  // Model: mtime after edge e is mt_b + ticks in (mt_w, e]; ticks fall on edges e with e % T == 0.
  int          tdiv [2] = '{4, 1};
  logic [63:0] mt_b   [2];
  int          mt_w   [2];
  logic [63:0] cmp_m  [2];
  logic        msip_m [2];
  logic        exp_t_prev [2];
  logic        exp_s_prev [2];

  always #5 clk = ~clk;

  ysyx_22041752_clint #(.BASE_ADDR(BASE), .TICK_DIV(4)) dut4 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wen(req_wen[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wstrb(req_wstrb[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]),
    .resp_err(resp_err[0]), .int_t_o(int_t_o[0]), .int_s_o(int_s_o[0])
  );

  ysyx_22041752_clint #(.BASE_ADDR(BASE), .TICK_DIV(1)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wen(req_wen[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wstrb(req_wstrb[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]),
    .resp_err(resp_err[1]), .int_t_o(int_t_o[1]), .int_s_o(int_s_o[1])
  );

  always @(posedge clk) begin
    if (reset) ecnt <= 0;
    else       ecnt <= ecnt + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mt(input int d, input int e);
    return mt_b[d] + 64'(e / tdiv[d] - mt_w[d] / tdiv[d]);
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] n,
                                        input logic [7:0] s);
    logic [63:0] r;
    r = o;
    for (int i = 0; i < 8; i++) if (s[i]) r[i*8 +: 8] = n[i*8 +: 8];
    return r;
  endfunction

  function automatic int dec(input logic [31:0] a);
    if (a[31:16] != BASE[31:16]) return 0;
    case ({a[15:3], 3'b000})
      16'h0000: return 1;
      16'h4000: return 2;
      16'hBFF8: return 3;
      default:  return 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mt_b[d] = '0; mt_w[d] = 0; cmp_m[d] = ONES; msip_m[d] = 1'b0;
    end
  endtask

  // Interrupt outputs after edge e must equal the compare on the register values after edge e-1.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        chk("int_t_o_track", int_t_o[d], exp_t_prev[d]);
        chk("int_s_o_track", int_s_o[d], exp_s_prev[d]);
      end
    end
    for (int d = 0; d < 2; d++) begin
      exp_t_prev[d] = (mt(d, ecnt) >= cmp_m[d]);
      exp_s_prev[d] = msip_m[d];
    end
  end

  // Called at posedge+1 with the FSM idle; returns at posedge+1 after the retire edge.
  task automatic xact(input int d, input logic wen, input logic [31:0] addr,
                      input logic [63:0] wdata, input logic [7:0] wstrb, input int hold,
                      output logic [63:0] rd, output logic err, output int w);
    logic [63:0] erd;
    logic        eerr;
    int          s;
    chk("req_ready_idle", req_ready[d], 64'd1);
    req_valid[d] = 1'b1; req_wen[d] = wen; req_addr[d] = addr;
    req_wdata[d] = wdata; req_wstrb[d] = wstrb; resp_ready[d] = (hold == 0);
    @(posedge clk); #1;
    w = ecnt;
    req_valid[d] = 1'b0;
    s = dec(addr);
    erd = '0;
    eerr = (s == 0);
    if (!wen) begin
      case (s)
        1: erd = {63'd0, msip_m[d]};
        2: erd = cmp_m[d];
        3: erd = mt(d, w - 1);
        default: erd = '0;
      endcase
    end else begin
      case (s)
        1: if (wstrb[0]) msip_m[d] = wdata[0];
        2: cmp_m[d] = merge(cmp_m[d], wdata, wstrb);
        3: begin mt_b[d] = merge(mt(d, w - 1), wdata, wstrb); mt_w[d] = w; end
        default: ;
      endcase
    end
    @(negedge clk);
    chk("resp_valid_after_accept", resp_valid[d], 64'd1);
    chk("req_ready_in_resp", req_ready[d], 64'd0);
    chk("resp_rdata", resp_rdata[d], erd);
    chk("resp_err", resp_err[d], eerr);
    rd = resp_rdata[d];
    err = resp_err[d];
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("held_resp_valid", resp_valid[d], 64'd1);
      chk("held_req_ready", req_ready[d], 64'd0);
      chk("held_rdata", resp_rdata[d], erd);
      chk("held_err", resp_err[d], eerr);
    end
    resp_ready[d] = 1'b1;
    @(posedge clk); #1;
    chk("resp_valid_retired", resp_valid[d], 64'd0);
    chk("req_ready_after_retire", req_ready[d], 64'd1);
  endtask

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic [63:0] rd;
    logic        err;
    logic        use_rd;
  } vec_t;

  function automatic vec_t mk(input logic wen, input logic [31:0] addr, input logic [63:0] wdata,
                              input logic [7:0] wstrb, input logic [63:0] rd, input logic err,
                              input logic use_rd);
    vec_t v;
    v.wen = wen; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb;
    v.rd = rd; v.err = err; v.use_rd = use_rd;
    return v;
  endfunction

  vec_t tbl [20];

  initial begin
    logic [63:0] rd, rd2;
    logic        err;
    int          w, w2;
    bit          found;

    tbl[0]  = mk(1, BASE + 32'h0000, 64'd0, 8'h01, 64'd0, 0, 1);
    tbl[1]  = mk(0, BASE + 32'h0000, 64'd0, 8'h00, 64'd0, 0, 1);
    tbl[2]  = mk(0, BASE + 32'h1000, 64'd0, 8'h00, 64'd0, 1, 1);
    tbl[3]  = mk(1, BASE + 32'h1000, ONES,  8'hFF, 64'd0, 1, 1);
    tbl[4]  = mk(0, BASE + 32'h8000, 64'd0, 8'h00, 64'd0, 1, 1);
    tbl[5]  = mk(0, BASE + 32'h1_0000, 64'd0, 8'h00, 64'd0, 1, 1);
    tbl[6]  = mk(0, 32'h0300_4000, 64'd0, 8'h00, 64'd0, 1, 1);
    tbl[7]  = mk(1, BASE + 32'h4000, 64'h1122_3344_5566_7788, 8'hFF, 64'd0, 0, 1);
    tbl[8]  = mk(0, BASE + 32'h4000, 64'd0, 8'h00, 64'h1122_3344_5566_7788, 0, 1);
    tbl[9]  = mk(1, BASE + 32'h4000, 64'hAAAA_AAAA_AAAA_AAAA, 8'h81, 64'd0, 0, 1);
    tbl[10] = mk(0, BASE + 32'h4004, 64'd0, 8'h00, 64'hAA22_3344_5566_77AA, 0, 1);
    tbl[11] = mk(1, BASE + 32'h0000, ONES,  8'hFF, 64'd0, 0, 1);
    tbl[12] = mk(0, BASE + 32'h0000, 64'd0, 8'h00, 64'd1, 0, 1);
    tbl[13] = mk(1, BASE + 32'h0000, 64'd0, 8'hFE, 64'd0, 0, 1);
    tbl[14] = mk(0, BASE + 32'h0000, 64'd0, 8'h00, 64'd1, 0, 1);
    tbl[15] = mk(1, BASE + 32'h0000, 64'd0, 8'h01, 64'd0, 0, 1);
    tbl[16] = mk(0, BASE + 32'h0007, 64'd0, 8'h00, 64'd0, 0, 1);
    tbl[17] = mk(1, BASE + 32'h4000, ONES,  8'hFF, 64'd0, 0, 1);
    tbl[18] = mk(0, BASE + 32'hBFF8, 64'd0, 8'h00, 64'd0, 0, 0);
    tbl[19] = mk(0, BASE + 32'hBFFC, 64'd0, 8'h00, 64'd0, 0, 0);

    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 0; req_wen[d] = 0; req_addr[d] = '0;
      req_wdata[d] = '0; req_wstrb[d] = '0; resp_ready[d] = 1;
    end
    model_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_req_ready", req_ready[d], 64'd1);
      chk("reset_resp_valid", resp_valid[d], 64'd0);
      chk("reset_resp_rdata", resp_rdata[d], 64'd0);
      chk("reset_resp_err", resp_err[d], 64'd0);
      chk("reset_int_t", int_t_o[d], 64'd0);
      chk("reset_int_s", int_s_o[d], 64'd0);
    end
    reset = 1'b0;
    mon_en = 1'b1;

    xact(0, 0, BASE + 32'h4000, 0, 0, 0, rd, err, w);
    chk("reset_mtimecmp_read", rd, ONES);

    // Count and compare with TICK_DIV = 4.
    xact(0, 1, BASE + 32'h4000, 64'd10, 8'hFF, 0, rd, err, w);
    xact(0, 0, BASE + 32'hBFF8, 0, 0, 0, rd, err, w);
    @(posedge clk); #1;
    @(posedge clk); #1;
    xact(0, 0, BASE + 32'hBFF8, 0, 0, 0, rd2, err, w2);
    chk("mtime_one_tick_per_4_cycles", rd2 - rd, 64'd1);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (mt(0, ecnt) == 64'd10) found = 1'b1;
    end
    chk("mtime_reached_10_in_budget", found, 64'd1);
    chk("int_t_low_when_mtime_hits_10", int_t_o[0], 64'd0);
    @(negedge clk);
    chk("int_t_high_one_cycle_later", int_t_o[0], 64'd1);
    @(posedge clk); #1;
    chk("int_t_high_before_cmp_raise", int_t_o[0], 64'd1);
    xact(0, 1, BASE + 32'h4000, ONES, 8'hFF, 0, rd, err, w);
    chk("int_t_dropped_two_edges_after", int_t_o[0], 64'd0);

    // Software interrupt.
    xact(0, 1, BASE + 32'h0000, 64'd1, 8'h01, 0, rd, err, w);
    chk("int_s_after_msip_write", int_s_o[0], 64'd1);

    // Wrap and byte lanes.
    xact(0, 1, BASE + 32'hBFF8, ONES - 64'd1, 8'hFF, 0, rd, err, w);
    repeat (10) @(posedge clk);
    #1;
    xact(0, 0, BASE + 32'hBFF8, 0, 0, 0, rd, err, w);
    chk("mtime_wrapped_small", (rd < 64'd2), 64'd1);
    xact(0, 1, BASE + 32'hBFF8, 64'h0000_0000_0000_AB00, 8'h02, 0, rd, err, w);
    xact(0, 0, BASE + 32'hBFF8, 0, 0, 0, rd, err, w);
    chk("byte1_written", rd[15:8], 64'hAB);
    chk("upper_bytes_unchanged", rd[63:16], 64'd0);

    // Write/tick collision with TICK_DIV = 1.
    xact(1, 1, BASE + 32'hBFF8, 64'd100, 8'hFF, 0, rd, err, w);
    xact(1, 0, BASE + 32'hBFF8, 0, 0, 0, rd, err, w2);
    chk("next_read_accept_edge", w2 - w, 64'd2);
    chk("collision_read_value", rd, 64'd101);

    // Backpressure.
    xact(0, 0, BASE + 32'h4000, 0, 0, 5, rd, err, w);
    xact(0, 0, BASE + 32'h1000, 0, 0, 5, rd, err, w);
    chk("unmapped_read_data", rd, 64'd0);
    chk("unmapped_read_err", err, 64'd1);

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 20; i++) begin
        xact(d, tbl[i].wen, tbl[i].addr, tbl[i].wdata, tbl[i].wstrb, 0, rd, err, w);
        if (tbl[i].use_rd) chk("table_rdata", rd, tbl[i].rd);
        chk("table_err", err, tbl[i].err);
      end
    end

    for (int i = 0; i < 160; i++) begin
      logic [31:0] a;
      int          sel;
      sel = $urandom_range(0, 4);
      case (sel)
        0: a = BASE + 32'h0000;
        1: a = BASE + 32'h4000;
        2: a = BASE + 32'hBFF8;
        3: a = BASE + 32'h2000;
        default: a = BASE + 32'h1_0000;
      endcase
      a[2:0] = 3'($urandom_range(0, 7));
      xact(i % 2, 1'($urandom_range(0, 1)), a, {$urandom, $urandom}, 8'($urandom),
           $urandom_range(0, 2), rd, err, w);
    end

    // Reset while a response is pending.
    req_valid[0] = 1; req_wen[0] = 0; req_addr[0] = BASE + 32'h4000; resp_ready[0] = 0;
    @(posedge clk); #1;
    req_valid[0] = 0;
    @(negedge clk);
    chk("pending_resp_before_reset", resp_valid[0], 64'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    @(posedge clk); #1;
    chk("midreset_resp_valid", resp_valid[0], 64'd0);
    chk("midreset_req_ready", req_ready[0], 64'd1);
    chk("midreset_rdata", resp_rdata[0], 64'd0);
    chk("midreset_err", resp_err[0], 64'd0);
    chk("midreset_int_s", int_s_o[0], 64'd0);
    reset = 1'b0;
    resp_ready[0] = 1;
    xact(0, 0, BASE + 32'h4000, 0, 0, 0, rd, err, w);
    chk("post_reset_mtimecmp", rd, ONES);
    xact(1, 0, BASE + 32'h0000, 0, 0, 0, rd, err, w);
    chk("post_reset_msip", rd, 64'd0);
    xact(1, 0, BASE + 32'hBFF8, 0, 0, 0, rd, err, w);
    chk("post_reset_mtime", rd, 64'(w - 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
